twiddle_gen: RTL
================

// Module: twiddle_gen
// PURPOSE
//  Parametrised FFT twiddle-factor generator. Replaces per-size hard-coded twiddle ROMs in the WISHBONE_FFT datapath.
//  Returns W = exp(-j*2*pi*p/N) for a runtime-selectable FFT size, using a quarter-wave sine table plus symmetry folding.
//  Has a 3-stage pipeline with valid/ready handshakes on the request and response sides. Sits between the FFT sequencer and the butterfly.
// PARAMETERS
//  DATA_WIDTH  16            twos-complement width of tw_re/tw_im; full scale is 2^(DATA_WIDTH-1)-1
//  LOG2_N      10            log2 of the largest supported FFT size; table holds 2^LOG2_N/4+1 entries
//  INIT_FILE   "qsin.hex"    $readmemh image of round(sin(2*pi*i/2^LOG2_N)*(2^(DATA_WIDTH-1)-1)), i=0..N/4
// PORTS
//  clk        in   1              single clock; all logic on posedge clk
//  rst        in   1              synchronous, active-high reset
//  fft_log2   in   4              runtime FFT size exponent, legal range 3..LOG2_N; sampled with each request
//  req_valid  in   1              request strobe
//  req_ready  out  1              request accepted when req_valid & req_ready
//  req_k      in   LOG2_N         twiddle exponent k; only the low fft_log2 bits are used
//  tw_valid   out  1              response valid
//  tw_ready   in   1              downstream accept
//  tw_re      out  DATA_WIDTH     real part of W
//  tw_im      out  DATA_WIDTH     imaginary part of W
//  cfg_err    out  1              sticky flag; set by any request with illegal fft_log2; cleared only by rst
// BEHAVIOUR
//  Reset: tw_valid=0, tw_re=0, tw_im=0, cfg_err=0, all pipe valids=0. req_ready=1 in the cycle after reset.
//  Index mapping: p = (req_k mod 2^fft_log2) << (LOG2_N-fft_log2), a LOG2_N-bit value.
//   quad = p[LOG2_N-1:LOG2_N-2]; r = p[LOG2_N-3:0]; Q = 2^(LOG2_N-2).
//  Table reads: s = T[r], c = T[Q-r]. The table is dual-read-port, so both reads happen in one cycle.
//  Fold by quadrant:
//   q0: re=+c, im=-s
//   q1: re=-s, im=-c
//   q2: re=-c, im=+s
//   q3: re=+s, im=+c
//  Negation is plain twos-complement. Table values never exceed 2^(DW-1)-1, so negation cannot overflow
//   (-0x7FFF=0x8001). -0 gives 0.
//  Illegal fft_log2 (<3 or >LOG2_N): the response is W=1 (re=2^(DW-1)-1, im=0), cfg_err sets the next cycle, and the pipeline keeps flowing.
//  Pipeline: S1 registers p/quad (and the CONJ flag); S2 does the table read (synchronous ROM); S3 applies fold and sign and registers outputs.
//   Latency from accept to tw_valid is 3 cycles. Throughput is 1 per clock while tw_ready=1.
//  Backpressure: stall = tw_valid & ~tw_ready. A stall freezes all stages, including the ROM read enable. req_ready = ~stall.
//   Holding outputs is mandatory: tw_re/tw_im stay stable while tw_valid=1 and tw_ready=0.
//  Bubbles: a stage with valid=0 may advance even while downstream is stalled only if it is empty. No request is ever dropped or duplicated.
//  Reset mid-operation flushes every in-flight request with no response, and clears cfg_err.
//  Changing fft_log2 between requests is legal; each request carries its own size through the pipe.
// CONFIGURATION
//  TWIDDLE_CONJ_EN defined: adds input port req_conj (1 bit, sampled with the request). When 1, the output is conj(W) (im negated after folding) for inverse FFT.
//  TWIDDLE_CONJ_EN undefined: no req_conj port; the forward twiddle is always produced.
// STRUCTURE
//  Shared package fft_pkg: FFT_MIN_LOG2=3, quadrant enum (Q0..Q3), the twiddle struct {re,im}, and the full-scale constant function.
//  Sub-module twiddle_qrom: (Q+1)-deep, two synchronous read ports, initialised from INIT_FILE, with a read-enable input for stall.
//  Top level holds the index mapping, handshake/stall control, fold/sign logic, and cfg_err.
// TESTING (DATA_WIDTH=16, LOG2_N=10 unless stated)
//  1. fft_log2=10 with k=0, 32, 128, 256 back-to-back: responses in order, first at +3 cycles, values:
//     7FFF/0000, 7D89/E707, 5A82/A57E, 0000/8001.
//  2. fft_log2=4, k=1 then k=12 -> 7641/CF05 then 0000/7FFF. Then fft_log2=10, k=768 in the next cycle -> 0000/7FFF.
//  3. Stream 16 requests with tw_ready toggled pseudo-randomly: req_ready drops only during stall, outputs stay stable while stalled,
//     and the scoreboard sees exactly 16 ordered, correct responses.
//  4. fft_log2=2 request -> 7FFF/0000 and cfg_err=1 thereafter. A following legal request returns the correct value; cfg_err clears only after rst.
//  5. Assert rst with 3 requests in flight -> no tw_valid afterwards, all outputs 0, and a new request 3 cycles later is correct.
//  6. TWIDDLE_CONJ_EN build: k=32, req_conj=1 -> 7D89/18F9. Same k with req_conj=0 -> 7D89/E707.
//     Sweep all k for every fft_log2 against a real-valued reference model within +/-1 LSB.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: size limits, quadrant encoding, twiddle pair type and
// the elaboration-time quarter-wave sine that fills the twiddle ROM.
package fft_pkg;

   localparam int FFT_MIN_LOG2 = 3;
   localparam int TW_MAX_W     = 32;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_e;

   typedef struct packed {
      logic signed [TW_MAX_W-1:0] re;
      logic signed [TW_MAX_W-1:0] im;
   } twiddle_t;

   function automatic longint full_scale(input int dw);
      return (longint'(1) << (dw - 1)) - 1;
   endfunction

   // round(sin(2*pi*i/2^log2n) * full_scale(dw)) in Q30 fixed point, Taylor to x^17;
   // error is far below 1e-3 LSB for the quarter wave.
   function automatic longint qsin_val(input int i, input int log2n, input int dw);
      longint pi_q30, x, x2, term, acc;
      pi_q30 = 64'sd3373259426;
      x      = (pi_q30 * 2 * longint'(i)) >>> log2n;
      x2     = (x * x) >>> 30;
      term   = x;
      acc    = x;
      for (int n = 1; n <= 8; n++) begin
         term = -((term * x2) >>> 30) / longint'(2 * n * (2 * n + 1));
         acc  = acc + term;
      end
      return (acc * full_scale(dw) + (longint'(1) << 29)) >>> 30;
   endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave sine ROM, Q+1 entries, two synchronous read ports sharing one enable.
// Contents are computed at elaboration and equal the qsin.hex image.
module twiddle_qrom
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LOG2_N     = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [LOG2_N-2:0]     addr_s,
   input  logic [LOG2_N-2:0]     addr_c,
   output logic [DATA_WIDTH-1:0] dout_s,
   output logic [DATA_WIDTH-1:0] dout_c
);

   localparam int DEPTH = (1 << (LOG2_N - 2)) + 1;

   logic [DATA_WIDTH-1:0] tbl [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
      localparam logic [DATA_WIDTH-1:0] V = DATA_WIDTH'(qsin_val(i, LOG2_N, DATA_WIDTH));
      assign tbl[i] = V;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         dout_s <= tbl[addr_s];
         dout_c <= tbl[addr_c];
      end
   end

endmodule

// File: rtl/twiddle_gen.sv
// FFT twiddle generator W = exp(-j*2*pi*p/N), 3-stage pipe with valid/ready.
// Define TWIDDLE_CONJ_EN to add the req_conj input (conjugated output for IFFT).
module twiddle_gen
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LOG2_N     = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            fft_log2,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [LOG2_N-1:0]     req_k,
`ifdef TWIDDLE_CONJ_EN
   input  logic                  req_conj,
`endif
   output logic                  tw_valid,
   input  logic                  tw_ready,
   output logic [DATA_WIDTH-1:0] tw_re,
   output logic [DATA_WIDTH-1:0] tw_im,
   output logic                  cfg_err
);

   localparam int Q  = 1 << (LOG2_N - 2);
   localparam int AW = LOG2_N - 1;

   logic [3:0]            vld_pipe;
   logic [2:0]            vld_q;
   logic                  stall, fire, legal, conj_in;
   logic [3:0]            sh;
   logic [LOG2_N-1:0]     p;
   quad_e                 quad1, quad2;
   logic [LOG2_N-3:0]     r1;
   logic                  conj1, conj2;
   logic [AW-1:0]         addr_s, addr_c;
   logic [DATA_WIDTH-1:0] s2, c2, re_n, im_n;

`ifdef TWIDDLE_CONJ_EN
   assign conj_in = req_conj;
`else
   assign conj_in = 1'b0;
`endif

   assign stall     = tw_valid & ~tw_ready;
   assign req_ready = ~stall;
   assign fire      = req_valid & req_ready;
   assign vld_pipe  = {vld_q, fire};
   assign tw_valid  = vld_pipe[3];

   // An illegal size maps to p=0, which folds naturally to W=1 (re=T[Q], im=-T[0]).
   assign legal = (fft_log2 >= 4'(FFT_MIN_LOG2)) && (fft_log2 <= 4'(LOG2_N));
   assign sh    = 4'(LOG2_N) - fft_log2;
   assign p     = legal ? (req_k << sh) : '0;

   // S1: index / quadrant
   always_ff @(posedge clk) begin
      if (!stall) begin
         quad1 <= quad_e'(p[LOG2_N-1 -: 2]);
         r1    <= p[LOG2_N-3:0];
         conj1 <= conj_in;
      end
   end

   // S2: table read, side info tracks the ROM latency
   assign addr_s = {1'b0, r1};
   assign addr_c = AW'(Q) - {1'b0, r1};

   twiddle_qrom #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG2_N     (LOG2_N)
   ) u_qrom (
      .clk    (clk),
      .en     (~stall),
      .addr_s (addr_s),
      .addr_c (addr_c),
      .dout_s (s2),
      .dout_c (c2)
   );

   always_ff @(posedge clk) begin
      if (!stall) begin
         quad2 <= quad1;
         conj2 <= conj1;
      end
   end

   // S3: quadrant fold and optional conjugate
   always_comb begin
      re_n = '0;
      im_n = '0;
      unique case (quad2)
         Q0: begin re_n =  c2; im_n = -s2; end
         Q1: begin re_n = -s2; im_n = -c2; end
         Q2: begin re_n = -c2; im_n =  s2; end
         Q3: begin re_n =  s2; im_n =  c2; end
      endcase
      if (conj2) im_n = -im_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= '0;
         tw_re   <= '0;
         tw_im   <= '0;
         cfg_err <= 1'b0;
      end else begin
         if (fire && !legal) cfg_err <= 1'b1;
         if (!stall) begin
            vld_q <= vld_pipe[2:0];
            // outputs only load real data so flushed junk never reaches them
            if (vld_pipe[2]) begin
               tw_re <= re_n;
               tw_im <= im_n;
            end
         end
      end
   end

endmodule
